// File: rtl/mem_stage_hs.sv
// rtl/mem_stage_hs.sv - handshaked memory pipeline stage (optional MEM_STAGE_MISALIGN_TRAP_EN)
module mem_stage_hs #(
  parameter int DW      = 32,
  parameter int AW      = 32,
  parameter int RW      = 5,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [7:0]        bundle_in,
  input  logic [AW-1:0]     address_in,
  input  logic [DW-1:0]     store_data_in,
  input  logic [RW-1:0]     write_reg_in,
  input  logic [AW-1:0]     pc_seq_in,
  output logic              valid_out,
  output logic [DW-1:0]     result_out,
  output logic [RW-1:0]     write_reg_out,
  output logic [1:0]        bundle_out,
  output logic [AW-1:0]     pc_seq_out,
  output logic              err_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic [DW/8-1:0]   mem_be,
  input  logic              mem_ack,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int BW = DW / 8;
  localparam int OW = $clog2(BW);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_t;

  state_t state, state_next;

  // captured op context, held for the duration of the request
  logic [1:0]    lsz_q;
  logic          sign_q;
  logic          sel_q;
  logic [OW-1:0] aoff_q;
  logic [AW-1:0] addr_q;
  logic [RW-1:0] wreg_q;
  logic [1:0]    pass_q;
  logic [AW-1:0] pc_q;
  logic [CW-1:0] wait_cnt;

  // decode of the incoming op
  logic          in_mem_op;
  logic [1:0]    in_lsz;
  logic [OW-1:0] in_off;
  logic [OW-1:0] size_mask;
  logic [OW-1:0] in_aoff;
  logic [BW-1:0] in_be;
  logic [DW-1:0] in_wdata;
  logic          trap;
  logic          accept;
  logic          timeout_hit;

  // load extraction at completion
  logic [63:0]   lane;
  logic [63:0]   ext;
  logic [DW-1:0] load_val;

  // decode size, lane offset, byte enables and replicated store data of the incoming op
  always_comb begin
    in_mem_op = bundle_in[3] | bundle_in[2];
    in_lsz    = (bundle_in[5:4] == 2'b11 && DW == 32) ? 2'b10 : bundle_in[5:4];
    in_off    = address_in[OW-1:0];
    case (in_lsz)
      2'd0:    size_mask = '0;
      2'd1:    size_mask = OW'(1);
      2'd2:    size_mask = OW'(3);
      default: size_mask = OW'(7);
    endcase
    in_aoff = in_off & ~size_mask;
    case (in_lsz)
      2'd0:    in_be = BW'(1) << in_aoff;
      2'd1:    in_be = BW'(3) << in_aoff;
      2'd2:    in_be = BW'(15) << in_aoff;
      default: in_be = '1;
    endcase
    case (in_lsz)
      2'd0:    in_wdata = {BW{store_data_in[7:0]}};
      2'd1:    in_wdata = {(DW/16){store_data_in[15:0]}};
      2'd2:    in_wdata = {(DW/32){store_data_in[31:0]}};
      default: in_wdata = store_data_in;
    endcase
  end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = |(in_off & size_mask);
  assign trap       = in_mem_op & misaligned;
`else
  assign trap = 1'b0;
`endif

  assign accept      = (state == IDLE) && valid_in;
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CW'(TIMEOUT - 1)) && !mem_ack;

  // select the addressed lane of the read data and extend it to the data width
  always_comb begin
    lane = 64'(mem_rdata >> {aoff_q, 3'b000});
    case (lsz_q)
      2'd0:    ext = sign_q ? {{56{lane[7]}},  lane[7:0]}  : {56'd0, lane[7:0]};
      2'd1:    ext = sign_q ? {{48{lane[15]}}, lane[15:0]} : {48'd0, lane[15:0]};
      2'd2:    ext = sign_q ? {{32{lane[31]}}, lane[31:0]} : {32'd0, lane[31:0]};
      default: ext = lane;
    endcase
    load_val = ext[DW-1:0];
  end

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // next state: one request in flight, released by ack or timeout
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (valid_in && in_mem_op && !trap) state_next = REQ;
      REQ:     if (mem_ack || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // handshake outputs decoded from state
  always_comb begin
    ready_out = (state == IDLE);
    mem_req   = (state == REQ);
  end

  // capture the op, drive the memory port registers and produce results
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lsz_q         <= '0;
      sign_q        <= 1'b0;
      sel_q         <= 1'b0;
      aoff_q        <= '0;
      addr_q        <= '0;
      wreg_q        <= '0;
      pass_q        <= '0;
      pc_q          <= '0;
      wait_cnt      <= '0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_be        <= '0;
      valid_out     <= 1'b0;
      result_out    <= '0;
      write_reg_out <= '0;
      bundle_out    <= '0;
      pc_seq_out    <= '0;
      err_out       <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (accept) begin
        lsz_q  <= in_lsz;
        sign_q <= bundle_in[6];
        sel_q  <= bundle_in[7];
        aoff_q <= in_aoff;
        addr_q <= address_in;
        wreg_q <= write_reg_in;
        pass_q <= bundle_in[1:0];
        pc_q   <= pc_seq_in;
        if (in_mem_op && !trap) begin
          wait_cnt  <= '0;
          mem_we    <= bundle_in[3];
          mem_addr  <= {address_in[AW-1:OW], {OW{1'b0}}};
          mem_wdata <= in_wdata;
          mem_be    <= in_be;
        end else begin
          valid_out     <= 1'b1;
          result_out    <= DW'(address_in);
          err_out       <= trap;
          write_reg_out <= write_reg_in;
          bundle_out    <= bundle_in[1:0];
          pc_seq_out    <= pc_seq_in;
        end
      end else if (state == REQ) begin
        if (mem_ack || timeout_hit) begin
          valid_out     <= 1'b1;
          write_reg_out <= wreg_q;
          bundle_out    <= pass_q;
          pc_seq_out    <= pc_q;
          if (mem_ack) begin
            result_out <= sel_q ? load_val : DW'(addr_q);
            err_out    <= 1'b0;
          end else begin
            result_out <= '0;
            err_out    <= 1'b1;
          end
        end else begin
          wait_cnt <= wait_cnt + CW'(1);
        end
      end
    end
  end

endmodule
